vector_wb_arbiter: RTL and testbench

VECTOR_WB_ARBITER -- requirements
Module: vector_wb_arbiter

---
 rtl/vector_wb_arbiter_pkg.sv | 23 ++
 rtl/vector_wb_arbiter_arb.sv | 37 +++
 rtl/vector_wb_arbiter.sv | 95 +++++++++
 tb/tb_vector_wb_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vector_wb_arbiter_pkg.sv
// Shared vector types and arbitration constants for the writeback path
// and the vector register file.
package vector_wb_arbiter_pkg;

  localparam int REG_SIZE     = 8;
  localparam int VEC_SIZE     = 4;
  localparam int REG_QUANTITY = 4;
  localparam int SEL_BITS     = 2;

  typedef logic [REG_SIZE-1:0] vecElem_t;
  typedef vecElem_t [VEC_SIZE-1:0] vector_t;

  // Grant vector layout: bit 0 = ALU, bit 1 = MEM.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_ALU  = 2'b01,
    GRANT_MEM  = 2'b10
  } grant_e;

  localparam logic PRIO_ALU = 1'b0;
  localparam logic PRIO_MEM = 1'b1;

endpackage

// File: rtl/vector_wb_arbiter_arb.sv
// Two-way round-robin arbiter: combinational grant from valid and an
// internal priority pointer that flips to the loser after every grant.
module rr_arbiter2
  import vector_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic prio;

  // No grants are issued while reset is held.
  always_comb begin
    grant = GRANT_NONE;
    if (rst) begin
      case (valid)
        2'b01:   grant = GRANT_ALU;
        2'b10:   grant = GRANT_MEM;
        2'b11:   grant = (prio == PRIO_ALU) ? GRANT_ALU : GRANT_MEM;
        default: grant = GRANT_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio <= PRIO_ALU;
    end else if (grant[0]) begin
      prio <= PRIO_MEM;
    end else if (grant[1]) begin
      prio <= PRIO_ALU;
    end
  end

endmodule

// File: rtl/vector_wb_arbiter.sv
// Vector writeback arbiter: merges ALU and memory-load writebacks onto one
// register-file write port and tracks per-register pending writes.
module vector_wb_arbiter
  import vector_wb_arbiter_pkg::*;
#(
  parameter int regSize     = REG_SIZE,
  parameter int regQuantity = REG_QUANTITY,
  parameter int selBits     = SEL_BITS,
  parameter int vecSize     = VEC_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              aluValid,
  input  logic [selBits-1:0]                aluReg,
  input  logic [vecSize-1:0][regSize-1:0]   aluData,
  output logic                              aluReady,
  input  logic                              memValid,
  input  logic [selBits-1:0]                memReg,
  input  logic [vecSize-1:0][regSize-1:0]   memData,
  output logic                              memReady,
  input  logic                              issueEn,
  input  logic [selBits-1:0]                issueReg,
  output logic                              regWrEn,
  output logic [selBits-1:0]                regToWrite,
  output logic [vecSize-1:0][regSize-1:0]   regWriteData,
  output logic [regQuantity-1:0]            busy
);

  logic [1:0] grant;

  rr_arbiter2 uArb (
    .clk   (clk),
    .rst   (rst),
    .valid ({memValid, aluValid}),
    .grant (grant)
  );

  assign aluReady = grant[0];
  assign memReady = grant[1];

  // ---- stage p0: select the granted request ----
  logic                            hs_p0;
  logic [selBits-1:0]              selReg_p0;
  logic [vecSize-1:0][regSize-1:0] selData_p0;

  assign hs_p0      = |grant;
  assign selReg_p0  = grant[1] ? memReg  : aluReg;
  assign selData_p0 = grant[1] ? memData : aluData;

  // ---- stage p1: registered write port ----
  logic                            vld_p1;
  logic [selBits-1:0]              wrReg_p1;
  logic [vecSize-1:0][regSize-1:0] wrData_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      wrReg_p1  <= '0;
      wrData_p1 <= '0;
    end else begin
      vld_p1 <= hs_p0;
      if (hs_p0) begin
        wrReg_p1  <= selReg_p0;
        wrData_p1 <= selData_p0;
      end
    end
  end

  assign regWrEn      = vld_p1;
  assign regToWrite   = wrReg_p1;
  assign regWriteData = wrData_p1;

  // Scoreboard: clear applied before set so an issue on the committing edge wins.
  logic [regQuantity-1:0] setMask;
  logic [regQuantity-1:0] clrMask;
  logic [regQuantity-1:0] busy_p1;

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (issueEn) setMask[issueReg] = 1'b1;
    if (vld_p1)  clrMask[wrReg_p1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_p1 <= '0;
    end else begin
      busy_p1 <= (busy_p1 & ~clrMask) | setMask;
    end
  end

  assign busy = busy_p1;

endmodule

// File: tb/tb_vector_wb_arbiter.sv
// Randomized and directed bench for vector_wb_arbiter against a rule-level
// model of arbitration, write commit and the busy scoreboard.
module tb_vector_wb_arbiter;
  import vector_wb_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          aluValid, memValid, issueEn;
  logic [1:0]    aluReg, memReg, issueReg;
  vector_t       aluData, memData;
  logic          aluReady, memReady, regWrEn;
  logic [1:0]    regToWrite;
  vector_t       regWriteData;
  logic [3:0]    busy;

  vector_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .aluValid     (aluValid),
    .aluReg       (aluReg),
    .aluData      (aluData),
    .aluReady     (aluReady),
    .memValid     (memValid),
    .memReg       (memReg),
    .memData      (memData),
    .memReady     (memReady),
    .issueEn      (issueEn),
    .issueReg     (issueReg),
    .regWrEn      (regWrEn),
    .regToWrite   (regToWrite),
    .regWriteData (regWriteData),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int nPass = 0;
  int nTotal = 0;

  // Reference model state
  logic        mPrio;
  logic [3:0]  mBusy;
  logic        mWrEn;
  logic [1:0]  mWrReg;
  logic [31:0] mWrData;
  logic        sA, sM;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTotal++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: check readies before the edge, update model, check outputs after.
  task automatic step();
    logic eA, eM;
    eA = rst && aluValid && (!memValid || mPrio == 1'b0);
    eM = rst && memValid && (!aluValid || mPrio == 1'b1);
    #1;
    sA = aluReady;
    sM = memReady;
    chk("aluReady", sA, eA);
    chk("memReady", sM, eM);
    @(posedge clk);
    if (!rst) begin
      mPrio = 1'b0; mBusy = '0; mWrEn = 1'b0; mWrReg = '0; mWrData = '0;
    end else begin
      if (mWrEn) mBusy[mWrReg] = 1'b0;
      if (issueEn) mBusy[issueReg] = 1'b1;
      mWrEn = eA || eM;
      if (eA) begin
        mWrReg = aluReg; mWrData = aluData; mPrio = 1'b1;
      end else if (eM) begin
        mWrReg = memReg; mWrData = memData; mPrio = 1'b0;
      end
    end
    #1;
    chk("regWrEn", regWrEn, mWrEn);
    chk("regToWrite", regToWrite, mWrReg);
    chk("regWriteData", regWriteData, mWrData);
    chk("busy", busy, mBusy);
  endtask

  task automatic idle();
    aluValid = 1'b0; memValid = 1'b0; issueEn = 1'b0;
  endtask

  initial begin
    mPrio = 1'b0; mBusy = '0; mWrEn = 1'b0; mWrReg = '0; mWrData = '0;
    rst = 1'b0; idle();
    aluReg = '0; memReg = '0; issueReg = '0; aluData = '0; memData = '0;
    @(posedge clk); #1;

    // Reset with requests pending: no grants, all outputs zero
    aluValid = 1'b1; memValid = 1'b1; issueEn = 1'b1; issueReg = 2'd1;
    step(); step();
    chk("rst_regWrEn", regWrEn, 1'b0);
    chk("rst_busy", busy, 4'b0000);
    chk("rst_regWriteData", regWriteData, 32'h0);
    rst = 1'b1; idle();

    // ALU-only write
    aluValid = 1'b1; aluReg = 2'd1; aluData = 32'hDEADBEEF;
    step();
    chk("alu_only_ready", sA, 1'b1);
    chk("alu_only_reg", regToWrite, 2'd1);
    chk("alu_only_data", regWriteData, 32'hDEADBEEF);
    idle(); step();
    chk("idle_wrEn", regWrEn, 1'b0);
    chk("idle_hold_data", regWriteData, 32'hDEADBEEF);

    // Both valid from reset: ALU,MEM,ALU,MEM
    rst = 1'b0; step(); rst = 1'b1;
    aluValid = 1'b1; aluReg = 2'd1; aluData = 32'h11111111;
    memValid = 1'b1; memReg = 2'd3; memData = 32'h1A2B3C4D;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_grant", {sA, sM}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_wrEn", regWrEn, 1'b1);
      chk("alt_data", regWriteData, (i % 2 == 0) ? 32'h11111111 : 32'h1A2B3C4D);
    end
    idle(); step();

    // Issue reg2, then MEM writes reg2
    issueEn = 1'b1; issueReg = 2'd2; step();
    issueEn = 1'b0;
    chk("busy_set", busy, 4'b0100);
    memValid = 1'b1; memReg = 2'd2; memData = 32'hCAFEF00D; step();
    memValid = 1'b0;
    chk("busy_during_write", busy, 4'b0100);
    chk("write_reg2", regToWrite, 2'd2);
    step();
    chk("busy_cleared", busy, 4'b0000);

    // Set wins over clear on reg3
    memValid = 1'b1; memReg = 2'd3; memData = 32'h01020304; step();
    memValid = 1'b0; issueEn = 1'b1; issueReg = 2'd3; step();
    issueEn = 1'b0;
    chk("set_wins", busy, 4'b1000);
    step();

    // Same destination from both: written in grant order
    rst = 1'b0; step(); rst = 1'b1;
    aluValid = 1'b1; aluReg = 2'd0; aluData = 32'hAAAAAAAA;
    memValid = 1'b1; memReg = 2'd0; memData = 32'h55555555;
    step();
    chk("same_first", regWriteData, 32'hAAAAAAAA);
    aluValid = 1'b0; step();
    chk("same_second", regWriteData, 32'h55555555);
    chk("same_reg", regToWrite, 2'd0);
    idle(); step();

    // Reset the cycle after a handshake drops the pending write
    aluValid = 1'b1; aluReg = 2'd2; aluData = 32'h0BADF00D;
    issueEn = 1'b1; issueReg = 2'd1; step();
    idle(); rst = 1'b0; step();
    chk("midrst_wrEn", regWrEn, 1'b0);
    chk("midrst_busy", busy, 4'b0000);
    rst = 1'b1;
    aluValid = 1'b1; memValid = 1'b1; step();
    chk("midrst_prio", {sA, sM}, 2'b10);
    idle(); step();

    // Randomized traffic with stable-hold on stalled requests
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      if (!(aluValid && !sA)) begin
        aluValid = $urandom_range(0, 2) != 0;
        aluReg   = 2'($urandom_range(0, 3));
        aluData  = $urandom();
      end
      if (!(memValid && !sM)) begin
        memValid = $urandom_range(0, 2) != 0;
        memReg   = 2'($urandom_range(0, 3));
        memData  = $urandom();
      end
      issueEn  = $urandom_range(0, 2) == 0;
      issueReg = 2'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
